// File: rtl/avalon_sdram_pattern_master_if.sv
// Avalon-MM bus bundle between the SDRAM pattern master and the controller's slave port.
interface avalon_sdram_pattern_master_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_sdram_pattern_master.sv
// SDRAM self-test initiator: writes seed+i to base+i over a word range, reads it back
// with pipelined reads and reports pass, a saturating error count and the first bad address.
module avalon_sdram_pattern_master #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int MAX_OUTST = 7
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    num_words,
    input  logic [DATA_W-1:0]    seed,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic [1:0]           state_dbg,
    avalon_sdram_pattern_master_if.master avm
);

    localparam int CW = ADDR_W + 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTST);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CW-1:0]       num_q, num_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [CW-1:0]       wr_idx_q, wr_idx_d;
    logic [CW-1:0]       rd_issued_q, rd_issued_d;
    logic [CW-1:0]       rsp_idx_q, rsp_idx_d;
    logic [OW-1:0]       outst_q, outst_d;
    logic                avm_read_q, avm_read_d;
    logic                avm_write_q, avm_write_d;
    logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
    logic [DATA_W-1:0]   avm_writedata_q, avm_writedata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;

    logic accept_wr, accept_rd;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] b, input logic [CW-1:0] idx);
        return b + ADDR_W'(idx);
    endfunction

    function automatic logic [DATA_W-1:0] data_of(input logic [DATA_W-1:0] s, input logic [CW-1:0] idx);
        return s + DATA_W'(idx);
    endfunction

    // Avalon handshake: a request (read or write) is taken by the slave on a rising edge where it
    // is asserted and waitrequest is low; until then request, address and data are held unchanged.
    assign accept_wr = avm_write_q && !avm.waitrequest;
    assign accept_rd = avm_read_q  && !avm.waitrequest;

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        num_d            = num_q;
        seed_d           = seed_q;
        wr_idx_d         = wr_idx_q;
        rd_issued_d      = rd_issued_q;
        rsp_idx_d        = rsp_idx_q;
        outst_d          = outst_q;
        avm_read_d       = avm_read_q;
        avm_write_d      = avm_write_q;
        avm_address_d    = avm_address_q;
        avm_writedata_d  = avm_writedata_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) state_d = S_IDLE;
                if (start) begin
                    base_d           = base_addr;
                    num_d            = {1'b0, num_words};
                    seed_d           = seed;
                    wr_idx_d         = '0;
                    rd_issued_d      = '0;
                    rsp_idx_d        = '0;
                    outst_d          = '0;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    busy_d           = 1'b1;
                    if (num_words == '0) begin
                        // Empty range: straight to the completion cycle, nothing on the bus.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = 1'b1;
                    end else begin
                        state_d         = S_WRITE;
                        avm_write_d     = 1'b1;
                        avm_address_d   = base_addr;
                        avm_writedata_d = seed;
                    end
                end
            end

            S_WRITE: begin
                if (accept_wr) begin
                    wr_idx_d = wr_idx_q + CW'(1);
                    if (wr_idx_d == num_q) begin
                        avm_write_d   = 1'b0;
                        avm_read_d    = 1'b1;
                        avm_address_d = base_q;
                        state_d       = S_READ;
                    end else begin
                        avm_address_d   = addr_of(base_q, wr_idx_d);
                        avm_writedata_d = data_of(seed_q, wr_idx_d);
                    end
                end
            end

            S_READ: begin
                rd_issued_d = rd_issued_q + CW'(accept_rd);
                case ({accept_rd, avm.readdatavalid})
                    2'b10:   outst_d = outst_q + OW'(1);
                    2'b01:   outst_d = outst_q - OW'(1);
                    default: outst_d = outst_q;
                endcase

                if (avm.readdatavalid) begin
                    if (avm.readdata != data_of(seed_q, rsp_idx_q)) begin
                        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                        if (err_count_q == 16'd0) first_err_addr_d = addr_of(base_q, rsp_idx_q);
                    end
                    rsp_idx_d = rsp_idx_q + CW'(1);
                end

                if (!(avm_read_q && avm.waitrequest)) begin
                    avm_read_d    = (rd_issued_d < num_q) && (outst_d < MAX_O);
                    avm_address_d = addr_of(base_q, rd_issued_d);
                end

                if (avm.readdatavalid && (rsp_idx_d == num_q)) begin
                    state_d    = S_DONE;
                    avm_read_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    pass_d     = (err_count_d == 16'd0);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q          <= S_IDLE;
            base_q           <= '0;
            num_q            <= '0;
            seed_q           <= '0;
            wr_idx_q         <= '0;
            rd_issued_q      <= '0;
            rsp_idx_q        <= '0;
            outst_q          <= '0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_address_q    <= '0;
            avm_writedata_q  <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            num_q            <= num_d;
            seed_q           <= seed_d;
            wr_idx_q         <= wr_idx_d;
            rd_issued_q      <= rd_issued_d;
            rsp_idx_q        <= rsp_idx_d;
            outst_q          <= outst_d;
            avm_read_q       <= avm_read_d;
            avm_write_q      <= avm_write_d;
            avm_address_q    <= avm_address_d;
            avm_writedata_q  <= avm_writedata_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign state_dbg      = state_q;

    assign avm.address    = avm_address_q;
    assign avm.read       = avm_read_q;
    assign avm.write      = avm_write_q;
    assign avm.writedata  = avm_writedata_q;
    assign avm.byteenable = '1;

endmodule

// File: tb/tb_avalon_sdram_pattern_master.sv
// Bench for the SDRAM pattern master: a behavioural Avalon slave with memory, stalls and
// configurable read latency, directed vector table, randomized vectors and a mid-write reset.
module tb_avalon_sdram_pattern_master;

  typedef struct {
    logic [23:0] base;
    logic [23:0] num;
    logic [15:0] seed;
    int          corrupt;
    logic [15:0] cx;
    int          wmode;
    int          lat;
    bit          spur;
    bit          exp_pass;
    logic [15:0] exp_err;
    logic [23:0] exp_first;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] base_addr = '0;
  logic [23:0] num_words = '0;
  logic [15:0] seed = '0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [23:0] first_err_addr;
  logic [1:0]  state_dbg;

  avalon_sdram_pattern_master_if #(.ADDR_W(24), .DATA_W(16)) avm();

  avalon_sdram_pattern_master #(.ADDR_W(24), .DATA_W(16), .MAX_OUTST(7)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .start          (start),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .state_dbg      (state_dbg),
    .avm            (avm)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err = 0;
  logic [39:0] exp_q[$];
  logic [15:0] mem [logic [23:0]];
  logic [15:0] rsp_q[$];
  int          rsp_t[$];
  int cyc = 0;
  int wmode = 0, lat = 1, corrupt = -1, spur = 0;
  logic [15:0] cx = '0;
  int wr_cnt, rd_cnt, rdv_cnt, pending, max_pending, hold_viol, both_viol, wr_stall, rd_stall;
  bit prev_stall = 0, prev_wr = 0, prev_rd = 0;
  logic [23:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural Avalon slave (acts at negedge) ----------------
  initial begin
    logic w;
    logic [15:0] d;
    logic [39:0] e;
    avm.waitrequest = 1'b0;
    avm.readdatavalid = 1'b0;
    avm.readdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        avm.waitrequest = 1'b0;
        avm.readdatavalid = 1'b0;
        rsp_q.delete();
        rsp_t.delete();
        pending = 0;
        prev_stall = 0;
        continue;
      end
      if (prev_stall) begin
        if (avm.write !== prev_wr || avm.read !== prev_rd || avm.address !== prev_addr ||
            (prev_wr && avm.writedata !== prev_data))
          hold_viol++;
      end
      if (avm.read && avm.write) both_viol++;

      w = 1'b0;
      if (wmode == 1) begin
        if (avm.write && wr_cnt == 1 && wr_stall < 3) begin w = 1'b1; wr_stall++; end
        else if (avm.read && rd_cnt == 2 && rd_stall < 3) begin w = 1'b1; rd_stall++; end
      end else if (wmode == 2) begin
        w = ($urandom_range(0, 99) < 30);
      end
      avm.waitrequest = w;

      if (rsp_q.size() > 0 && rsp_t[0] <= cyc) begin
        avm.readdatavalid = 1'b1;
        avm.readdata = rsp_q.pop_front();
        void'(rsp_t.pop_front());
        pending--;
        rdv_cnt++;
      end else if (spur != 0 && avm.write) begin
        avm.readdatavalid = 1'b1;
        avm.readdata = 16'h0BAD;
      end else begin
        avm.readdatavalid = 1'b0;
        avm.readdata = 16'($urandom);
      end

      if (avm.write && !w) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL extra_write: got %0h:%0h expected no beat", avm.address, avm.writedata);
        end else begin
          e = exp_q.pop_front();
          chk("write_beat", {24'h0, avm.address, avm.writedata}, {24'h0, e});
        end
        mem[avm.address] = avm.writedata;
        wr_cnt++;
      end
      if (avm.read && !w) begin
        d = mem.exists(avm.address) ? mem[avm.address] : 16'hDEAD;
        if (rd_cnt == corrupt) d = d ^ cx;
        rsp_q.push_back(d);
        rsp_t.push_back(cyc + lat);
        pending++;
        rd_cnt++;
      end
      if (pending > max_pending) max_pending = pending;
      prev_stall = (avm.read || avm.write) && w;
      prev_wr = avm.write;
      prev_rd = avm.read;
      prev_addr = avm.address;
      prev_data = avm.writedata;
    end
  end

  // ---------------- reference model ----------------
  // Expected outcome from the pattern rule: word i returns (seed+i) xor'd with cx at the corrupt index.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic [15:0] good, ret;
    r.exp_err = 0;
    r.exp_first = 0;
    for (int i = 0; i < int'(v.num); i++) begin
      good = v.seed + 16'(i);
      ret = (i == v.corrupt) ? (good ^ v.cx) : good;
      if (ret != good) begin
        if (r.exp_err == 0) r.exp_first = v.base + 24'(i);
        if (r.exp_err != 16'hFFFF) r.exp_err++;
      end
    end
    r.exp_pass = (r.exp_err == 0);
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic setup_slave(input vec_t v);
    wmode = v.wmode; lat = v.lat; corrupt = v.corrupt; cx = v.cx; spur = v.spur;
    wr_cnt = 0; rd_cnt = 0; rdv_cnt = 0; max_pending = 0;
    hold_viol = 0; both_viol = 0; wr_stall = 0; rd_stall = 0;
    exp_q.delete();
    for (int i = 0; i < int'(v.num); i++) exp_q.push_back({v.base + 24'(i), v.seed + 16'(i)});
  endtask

  task automatic pulse_start(input vec_t v);
    @(negedge clk);
    base_addr = v.base; num_words = v.num; seed = v.seed; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int cycles;
    setup_slave(v);
    pulse_start(v);
    cycles = 0;
    while (!done && cycles < 4000) begin
      @(negedge clk);
      cycles++;
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_pass"}, pass, v.exp_pass);
    chk({name, "_err_count"}, err_count, v.exp_err);
    chk({name, "_first_err"}, first_err_addr, v.exp_first);
    chk({name, "_writes"}, wr_cnt, v.num);
    chk({name, "_reads"}, rd_cnt, v.num);
    chk({name, "_responses"}, rdv_cnt, v.num);
    chk({name, "_outst_le_max"}, max_pending <= 7, 1);
    chk({name, "_stall_hold"}, hold_viol, 0);
    chk({name, "_rd_wr_excl"}, both_viol, 0);
    chk({name, "_all_beats"}, exp_q.size(), 0);
    if (v.num >= 8 && v.lat >= 10) chk({name, "_outst_full"}, max_pending, 7);
    if (v.num == 0) chk({name, "_quick_done"}, cycles <= 2, 1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_pass"}, pass, 0);
    chk({name, "_err_count"}, err_count, 0);
    chk({name, "_first_err"}, first_err_addr, 0);
    chk({name, "_read"}, avm.read, 0);
    chk({name, "_write"}, avm.write, 0);
    chk({name, "_address"}, avm.address, 0);
    chk({name, "_writedata"}, avm.writedata, 0);
    chk({name, "_state"}, state_dbg, 0);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[6];

  initial begin
    vec_t v;
    int cycles;
    //        base        num    seed      corr cx        wm lat spur pass err  first
    tbl[0] = '{24'h000100, 24'd4,  16'hA500, -1, 16'h0000, 0, 1,  0,   1,   0,   24'h0};
    tbl[1] = '{24'h000100, 24'd4,  16'hA500, -1, 16'h0000, 1, 1,  0,   1,   0,   24'h0};
    tbl[2] = '{24'h000100, 24'd4,  16'hA500,  2, 16'hA502, 0, 1,  0,   0,   1,   24'h000102};
    tbl[3] = '{24'h002000, 24'd16, 16'h1234, -1, 16'h0000, 0, 20, 0,   1,   0,   24'h0};
    tbl[4] = '{24'hFFFFFE, 24'd4,  16'h0042,  3, 16'h00FF, 0, 2,  0,   0,   1,   24'h000001};
    tbl[5] = '{24'h000010, 24'd0,  16'h0000, -1, 16'h0000, 0, 1,  0,   1,   0,   24'h0};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_in");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset_out");

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 10; i++) begin
      v.base = 24'($urandom);
      v.num = 24'($urandom_range(1, 40));
      v.seed = 16'($urandom);
      v.corrupt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, int'(v.num) - 1)) : -1;
      v.cx = 16'($urandom_range(1, 65535));
      v.wmode = 2;
      v.lat = $urandom_range(1, 25);
      v.spur = 1;
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // Reset while write beat 5 of 10 is on the bus, then a full clean run.
    v = '{24'h000500, 24'd10, 16'h7700, -1, 16'h0000, 0, 1, 0, 1, 0, 24'h0};
    setup_slave(v);
    pulse_start(v);
    cycles = 0;
    while (wr_cnt < 5 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    chk("reach_beat5", (cycles < 200) && avm.write, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec(v, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_sdram_pattern_master.md
Name: avalon_sdram_pattern_master

Overview:
Avalon-MM master that drives the SDRAM controller's Avalon-MM slave port from inside the system. On a start pulse it writes a deterministic pattern over a word range, reads the range back using pipelined reads, and compares each returned word. It reports pass/fail, a saturating error count and the first failing address. It serves as the bring-up and self-test initiator for the SDRAM subsystem.

Parameters:
ADDR_W, 24, Avalon word-address width (16M x16 SDRAM).
DATA_W, 16, Avalon data width.
MAX_OUTST, 7, maximum pipelined reads in flight; matches the controller's pending-read depth.

Ports:
clk_clk  in  1  system clock; all logic on its rising edge
reset_reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle start request; ignored while busy=1
base_addr  in  ADDR_W  first word address; sampled on an accepted start
num_words  in  ADDR_W  number of words to test; sampled on an accepted start
seed  in  DATA_W  pattern seed; sampled on an accepted start
busy  out  1  test in progress
done  out  1  high from test completion until the next accepted start
pass  out  1  valid while done=1; 1 = no mismatches
err_count  out  16  mismatch count, saturates at 0xFFFF
first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none
avm_address  out  ADDR_W  Avalon word address
avm_read  out  1  read request
avm_write  out  1  write request
avm_writedata  out  DATA_W  write data
avm_byteenable  out  DATA_W/8  always all ones
avm_readdata  in  DATA_W  read data
avm_readdatavalid  in  1  read data valid
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset (asynchronous, reset_reset_n=0): state IDLE. busy, done, pass, avm_read and avm_write are 0. err_count, first_err_addr, avm_address and avm_writedata are 0. All counters are cleared.
- Pattern: word i (0-based) has address (base_addr+i) mod 2^ADDR_W and data (seed+i) mod 2^DATA_W.
- States:
  - IDLE: an accepted start latches the inputs, clears done, pass, err_count and first_err_addr, and sets busy. If num_words=0, go to DONE; otherwise go to WRITE.
  - WRITE: avm_write=1 with address and data for word wr_idx. The beat is accepted when avm_write=1 and avm_waitrequest=0; wr_idx then increments. While stalled, address and data are held stable. After the last beat is accepted, avm_write drops in the next cycle and the state goes to READ. There are no idle cycles between accepted beats.
  - READ: avm_read=1 iff rd_issued<num_words and outst<MAX_OUTST. Once asserted, avm_read and avm_address are held until accepted. A read is accepted when avm_read=1 and avm_waitrequest=0; this increments rd_issued.
    - outst increments on an accepted read and decrements on readdatavalid. Both in the same cycle leave outst unchanged.
    - Each readdatavalid compares avm_readdata with the pattern for rsp_idx, then increments rsp_idx. Responses are in order.
    - On a mismatch, err_count increments (saturating). If this is the first mismatch, first_err_addr captures the response address.
    - When rsp_idx reaches num_words, go to DONE.
  - DONE: for one cycle, done=1, busy=0, pass=(err_count==0); then go to IDLE. done and pass stay valid in IDLE.
- avm_read and avm_write are never both 1.
- readdatavalid in IDLE, DONE or WRITE is ignored.
- start while busy is ignored.
- Address arithmetic wraps modulo 2^ADDR_W. Counters are ADDR_W+1 bits wide so that num_words = 2^ADDR_W-1 terminates.
- Reset mid-operation aborts immediately and returns to the reset state. In-flight responses arriving after reset are ignored.

Test Plan:
- Zero-wait slave model, base=0x000100, num=4, seed=0xA500 -> writes A500..A503 to 0x100..0x103 on 4 consecutive cycles. Reads return the same data. Result: done=1, pass=1, err_count=0.
- avm_waitrequest high for 3 cycles on write beat 1 and read 2 -> address and data held stable during each stall, no beat duplicated, pass=1.
- Slave corrupts the read of word 2 (returns 0x0000) -> err_count=1, first_err_addr=0x000102, pass=0.
- Slave delays readdatavalid by 20 cycles, num=16 -> outst never exceeds 7, all 16 words compared, pass=1.
- base=0xFFFFFE, num=4 -> addresses FFFFFE, FFFFFF, 000000, 000001. Also num=0 -> no bus activity, done=1 and pass=1 within 2 cycles of start.
- Assert reset_reset_n=0 during WRITE beat 5 of 10 -> all outputs return to reset values asynchronously. A subsequent start runs a full, clean test.
